// File: rtl/ctrl_pipe.sv
// Control-path pipeline for the MIPS core: carries decode controls through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, squashes illegal opcodes and counts retired instructions.
module ctrl_pipe #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic            illegal_d,
  input  logic            regwrite_d,
  input  logic            regdst_d,
  input  logic            alusrc_d,
  input  logic            memwrite_d,
  input  logic            memtoreg_d,
  input  logic [1:0]      aluop_d,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rd_d,
  input  logic            flush_e_in,
  output logic            stall_f,
  output logic            stall_d,
  output logic            regwrite_e,
  output logic            alusrc_e,
  output logic            regdst_e,
  output logic            memwrite_e,
  output logic            memtoreg_e,
  output logic [1:0]      aluop_e,
  output logic [REGW-1:0] rs_e,
  output logic [REGW-1:0] rt_e,
  output logic [REGW-1:0] rd_e,
  output logic            regwrite_m,
  output logic            memwrite_m,
  output logic            memtoreg_m,
  output logic [REGW-1:0] writereg_m,
  output logic            regwrite_w,
  output logic            memtoreg_w,
  output logic [REGW-1:0] writereg_w,
  output logic            illegal_flag,
  output logic [CNTW-1:0] retired
);

  logic v_e, v_m, v_w;
  logic lwstall;

  // Conservative: register 0 is not excluded from the compare.
  assign lwstall = v_e & memtoreg_e & ((rs_d == rt_e) | (rt_d == rt_e));
  assign stall_f = lwstall;
  assign stall_d = lwstall;

  // ID/EX: the bubble paths never look at the control inputs, so X cannot leak past decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_e          <= 1'b0;
      regwrite_e   <= 1'b0;
      regdst_e     <= 1'b0;
      alusrc_e     <= 1'b0;
      memwrite_e   <= 1'b0;
      memtoreg_e   <= 1'b0;
      aluop_e      <= 2'b00;
      rs_e         <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
      illegal_flag <= 1'b0;
    end else if (lwstall || flush_e_in || (valid_d && illegal_d)) begin
      v_e        <= 1'b0;
      regwrite_e <= 1'b0;
      regdst_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      memwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      aluop_e    <= 2'b00;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      if (!lwstall && !flush_e_in) begin
        illegal_flag <= 1'b1;
      end
    end else if (valid_d) begin
      v_e        <= 1'b1;
      regwrite_e <= regwrite_d;
      regdst_e   <= regdst_d;
      alusrc_e   <= alusrc_d;
      memwrite_e <= memwrite_d;
      memtoreg_e <= memtoreg_d;
      aluop_e    <= aluop_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
    end else begin
      v_e        <= 1'b0;
      regwrite_e <= 1'b0;
      regdst_e   <= 1'b0;
      alusrc_e   <= 1'b0;
      memwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      aluop_e    <= 2'b00;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
    end
  end

  // EX/MEM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_m        <= 1'b0;
      regwrite_m <= 1'b0;
      memwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      writereg_m <= '0;
    end else begin
      v_m        <= v_e;
      regwrite_m <= v_e & regwrite_e;
      memwrite_m <= v_e & memwrite_e;
      memtoreg_m <= v_e & memtoreg_e;
      writereg_m <= v_e ? (regdst_e ? rd_e : rt_e) : '0;
    end
  end

  // MEM/WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_w        <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      writereg_w <= '0;
    end else begin
      v_w        <= v_m;
      regwrite_w <= regwrite_m;
      memtoreg_w <= memtoreg_m;
      writereg_w <= writereg_m;
    end
  end

  // Wraps silently at 2^CNTW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (v_w) begin
      retired <= retired + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: an ID/EX reference tracks hazards, MEM and WB expectations
// are queued with their due cycle, and the retire counter runs 4 bits wide to exercise wrap.
module tb_ctrl_pipe;
  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 4;

  logic clk = 1'b0;
  logic reset;
  logic valid_d, illegal_d, regwrite_d, regdst_d, alusrc_d, memwrite_d, memtoreg_d;
  logic [1:0] aluop_d;
  logic [REGW-1:0] rs_d, rt_d, rd_d;
  logic flush_e_in;
  logic stall_f, stall_d;
  logic regwrite_e, alusrc_e, regdst_e, memwrite_e, memtoreg_e;
  logic [1:0] aluop_e;
  logic [REGW-1:0] rs_e, rt_e, rd_e;
  logic regwrite_m, memwrite_m, memtoreg_m;
  logic [REGW-1:0] writereg_m;
  logic regwrite_w, memtoreg_w;
  logic [REGW-1:0] writereg_w;
  logic illegal_flag;
  logic [CNTW-1:0] retired;

  ctrl_pipe #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .illegal_d(illegal_d),
    .regwrite_d(regwrite_d), .regdst_d(regdst_d), .alusrc_d(alusrc_d),
    .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d), .aluop_d(aluop_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e_in(flush_e_in),
    .stall_f(stall_f), .stall_d(stall_d),
    .regwrite_e(regwrite_e), .alusrc_e(alusrc_e), .regdst_e(regdst_e),
    .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e), .aluop_e(aluop_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_m(writereg_m), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
    .writereg_w(writereg_w), .illegal_flag(illegal_flag), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t qm[$];
  exp_t qw[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic e_v, e_mtr;
  logic [REGW-1:0] e_rt;
  logic [21:0] ex_exp;
  logic [CNTW-1:0] exp_ret;
  logic exp_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    qm.delete();
    qw.delete();
    e_v = 1'b0;
    e_mtr = 1'b0;
    e_rt = '0;
    ex_exp = '0;
    exp_ret = '0;
    exp_ill = 1'b0;
  endtask

  task automatic check_outputs();
    logic wb_due;
    check_eq("ex", {regwrite_e, regdst_e, alusrc_e, memwrite_e, memtoreg_e, aluop_e,
                    rs_e, rt_e, rd_e}, 32'(ex_exp));
    if (qm.size() > 0 && qm[0].due == cyc) begin
      check_eq("mem", {regwrite_m, memwrite_m, memtoreg_m, writereg_m}, 32'(qm[0].val));
      void'(qm.pop_front());
    end else begin
      check_eq("mem_bubble", {regwrite_m, memwrite_m, memtoreg_m, writereg_m}, 32'd0);
    end
    wb_due = (qw.size() > 0 && qw[0].due == cyc);
    if (wb_due) begin
      check_eq("wb", {regwrite_w, memtoreg_w, writereg_w}, 32'(qw[0].val));
      void'(qw.pop_front());
    end else begin
      check_eq("wb_bubble", {regwrite_w, memtoreg_w, writereg_w}, 32'd0);
    end
    check_eq("retired", 32'(retired), 32'(exp_ret));
    check_eq("illegal_flag", 32'(illegal_flag), 32'(exp_ill));
    check_eq("no_x", 32'($isunknown({stall_f, stall_d, regwrite_e, alusrc_e, regdst_e,
      memwrite_e, memtoreg_e, aluop_e, rs_e, rt_e, rd_e, regwrite_m, memwrite_m, memtoreg_m,
      writereg_m, regwrite_w, memtoreg_w, writereg_w, illegal_flag, retired})), 32'd0);
    if (wb_due) exp_ret = exp_ret + 1'b1;
  endtask

  // One clock: drive decode inputs, check the hazard, clock, then check every stage.
  task automatic step(input logic v, il, rw, rdst, as, mw, mtr, input logic [1:0] op,
                      input logic [REGW-1:0] rs, rt, rd, input logic fl, output logic st);
    exp_t r;
    valid_d = v; illegal_d = il; regwrite_d = rw; regdst_d = rdst; alusrc_d = as;
    memwrite_d = mw; memtoreg_d = mtr; aluop_d = op; rs_d = rs; rt_d = rt; rd_d = rd;
    flush_e_in = fl;
    #1;
    st = e_v & e_mtr & ((rs == e_rt) | (rt == e_rt));
    check_eq("stall_f", 32'(stall_f), 32'(st));
    check_eq("stall_d", 32'(stall_d), 32'(st));
    if (st || fl || (v && il) || !v) begin
      if (!st && !fl && v && il) exp_ill = 1'b1;
      e_v = 1'b0; e_mtr = 1'b0; e_rt = '0; ex_exp = '0;
    end else begin
      e_v = 1'b1; e_mtr = mtr; e_rt = rt;
      ex_exp = {rw, rdst, as, mw, mtr, op, rs, rt, rd};
      r.due = cyc + 2;
      r.val = {rw, mw, mtr, (rdst ? rd : rt)};
      qm.push_back(r);
      r.due = cyc + 3;
      r.val = {1'b0, rw, mtr, (rdst ? rd : rt)};
      qw.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  // Re-presents the same instruction while the reference predicts a load-use stall.
  task automatic issue(input logic rw, rdst, as, mw, mtr, input logic [1:0] op,
                       input logic [REGW-1:0] rs, rt, rd);
    logic st;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, rw, rdst, as, mw, mtr, op, rs, rt, rd, 1'b0, st);
      if (!st) break;
    end
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, st);
  endtask

  task automatic radd(input logic [REGW-1:0] rs, rt, rd);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, rs, rt, rd);
  endtask

  initial begin
    logic st;
    reset = 1'b1;
    valid_d = 0; illegal_d = 0; regwrite_d = 0; regdst_d = 0; alusrc_d = 0;
    memwrite_d = 0; memtoreg_d = 0; aluop_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    flush_e_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    // R-type add: rt=2, rd=3
    radd(5'd1, 5'd2, 5'd3);
    idle(4);

    // Load-use: lw rt=2, then add rs=2 stalls once
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 5'd4, 5'd2, 5'd0);
    radd(5'd2, 5'd5, 5'd6);
    idle(4);

    // Flushed store never reaches EX or MEM
    step(1, 0, 0, 0, 1, 1, 0, 2'b00, 5'd4, 5'd7, 5'd0, 1, st);
    idle(4);

    // Illegal together with flush: flush wins, flag stays clear
    step(1, 1, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 2'bxx, 5'd1, 5'd1, 5'd1, 1, st);
    idle(2);

    // Load-use together with flush: stall still asserted, one bubble
    issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 5'd0, 5'd3, 5'd0);
    step(1, 0, 1, 1, 0, 0, 0, 2'b10, 5'd3, 5'd4, 5'd5, 1, st);
    idle(4);

    // Illegal opcode with X controls
    step(1, 1, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 2'bxx, 5'd0, 5'd0, 5'd0, 0, st);
    idle(4);

    // Asynchronous reset with three R-types in flight
    radd(5'd1, 5'd2, 5'd8);
    radd(5'd1, 5'd2, 5'd9);
    radd(5'd1, 5'd2, 5'd10);
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_async", 32'({stall_f, stall_d, regwrite_e, alusrc_e, regdst_e, memwrite_e,
      memtoreg_e, aluop_e, rs_e, rt_e, rd_e}), 32'd0);
    check_eq("reset_async_mw", 32'({regwrite_m, memwrite_m, memtoreg_m, writereg_m,
      regwrite_w, memtoreg_w, writereg_w, illegal_flag, retired}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle(2);

    // 17 back-to-back R-types wrap the 4-bit counter
    for (int i = 0; i < 17; i++) radd(5'(i), 5'(i + 1), 5'(i + 2));
    idle(5);

    if (qm.size() != 0 || qw.size() != 0) begin
      n_fail++;
      $display("FAIL drain: mem_left=%0d wb_left=%0d expected=0", qm.size(), qw.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
